// File: rtl/lcd_scroll_sequencer.sv
// -----------------------------------------------------------------------------
// lcd_scroll_sequencer
//
// Produces the 16-character top row of the 16x2 LCD frame by rotating a
// stored message window one character per scroll tick. After each full
// rotation it pauses for HOLD_STEPS ticks. line_out feeds chars[255:128] of
// the LCD driver.
//
// Parameters:
//   MSG_LEN    message length in characters (>= 16)
//   TICK_DIV   clk cycles per scroll step (>= 2)
//   HOLD_STEPS ticks spent paused after a wrap (0 = no pause)
//
// Ports:
//   clk      system clock
//   rst      asynchronous, active-high reset
//   en       1 = scrolling allowed, 0 = freeze (block drops to IDLE)
//   dir      0 = scroll left (offset increments), 1 = scroll right
//   load     one-cycle strobe, captures msg_in and restarts at offset 0
//   msg_in   message, char 0 in the MSBs (string-literal order)
//   line_out registered 16-char window, char 0 in [127:120]
//   busy     1 whenever the FSM is not in IDLE
//   wrap     one-cycle pulse, coincident with the line_out update that wrapped
//
// Control semantics: load and en are level-sampled on every rising clk edge;
// there is no handshake. load takes priority over a scroll tick in the same
// cycle, and en=0 suppresses any tick.
//
// Optional build macro LCD_SCROLL_BOUNCE_EN: ping-pong scrolling. The offset
// moves between 0 and MSG_LEN-16 and reverses at each end instead of wrapping
// circularly; each reversal pulses wrap and enters the hold pause. dir is only
// sampled on load or when leaving IDLE.
//
// The FSM state is held in state_q (enum state_t) for checker binding.
// -----------------------------------------------------------------------------
module lcd_scroll_sequencer #(
  parameter int MSG_LEN    = 20,
  parameter int TICK_DIV   = 12_500_000,
  parameter int HOLD_STEPS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 dir,
  input  logic                 load,
  input  logic [8*MSG_LEN-1:0] msg_in,
  output logic [127:0]         line_out,
  output logic                 busy,
  output logic                 wrap
);

  localparam int OW = $clog2(MSG_LEN);
  localparam int IW = OW + 1;
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int HW = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;

  localparam logic [PW-1:0]        PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [HW-1:0]        HOLD_LAST  = HW'((HOLD_STEPS > 0) ? HOLD_STEPS - 1 : 0);
  localparam logic [127:0]         BLANK_LINE = {16{8'h20}};
  localparam logic [8*MSG_LEN-1:0] BLANK_MSG  = {MSG_LEN{8'h20}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [8*MSG_LEN-1:0] msg_q;
  logic [OW-1:0]        offset_q;
  logic [OW-1:0]        offset_step;
  logic [PW-1:0]        presc_q;
  logic [HW-1:0]        hold_q;
  logic                 tick;
  logic                 do_step;
  logic                 hold_done;
  logic                 step_wraps;

  // Window extraction: char j comes from message index (off + j) mod MSG_LEN.
  // The sum is formed one bit wider than the offset; since off + 15 is always
  // below 2*MSG_LEN a single conditional subtract is a full modulo.
  function automatic logic [127:0] window(input logic [8*MSG_LEN-1:0] m,
                                          input logic [OW-1:0]        off);
    logic [IW-1:0] idx;
    logic [127:0]  w;
    w = '0;
    for (int j = 0; j < 16; j++) begin
      idx = {1'b0, off} + IW'(j);
      if (idx >= IW'(MSG_LEN)) idx = idx - IW'(MSG_LEN);
      w[8*(15-j) +: 8] = m[8*(MSG_LEN-1-int'(idx)) +: 8];
    end
    return w;
  endfunction

  // Tick and step qualifiers shared by the FSM and the datapath.
  always_comb begin : p_tick
    tick      = (state_q != ST_IDLE) && (presc_q == PRESC_LAST);
    do_step   = tick && en && !load && (state_q == ST_RUN);
    hold_done = tick && en && !load && (state_q == ST_HOLD) && (hold_q == HOLD_LAST);
  end

`ifdef LCD_SCROLL_BOUNCE_EN
  localparam logic [OW-1:0] OFF_MAX = OW'(MSG_LEN - 16);

  logic dir_q;     // 0 = moving towards OFF_MAX, 1 = moving towards 0
  logic dir_step;  // direction flag after the pending step
  logic step_up;

  // Direction is corrected at an end before stepping, so a flag loaded from
  // dir that points off the range (e.g. dir=1 at offset 0) still steps inward.
  always_comb begin : p_step
    offset_step = offset_q;
    step_wraps  = 1'b0;
    dir_step    = dir_q;
    step_up     = 1'b0;
    if (MSG_LEN > 16) begin
      step_up = (!dir_q && (offset_q != OFF_MAX)) || (dir_q && (offset_q == '0));
      if (step_up) begin
        offset_step = offset_q + OW'(1);
        step_wraps  = (offset_step == OFF_MAX);
      end else begin
        offset_step = offset_q - OW'(1);
        step_wraps  = (offset_step == '0);
      end
      dir_step = step_wraps ? step_up : !step_up;
    end
  end

  always_ff @(posedge clk or posedge rst) begin : p_dir
    if (rst) begin
      dir_q <= 1'b0;
    end else if (load || ((state_q == ST_IDLE) && en)) begin
      dir_q <= dir;
    end else if (do_step) begin
      dir_q <= dir_step;
    end
  end
`else
  localparam logic [OW-1:0] OFF_LAST = OW'(MSG_LEN - 1);

  always_comb begin : p_step
    offset_step = offset_q;
    step_wraps  = 1'b0;
    if (dir) begin
      if (offset_q == '0) begin
        offset_step = OFF_LAST;
        step_wraps  = 1'b1;
      end else begin
        offset_step = offset_q - OW'(1);
      end
    end else begin
      if (offset_q == OFF_LAST) begin
        offset_step = '0;
        step_wraps  = 1'b1;
      end else begin
        offset_step = offset_q + OW'(1);
      end
    end
  end
`endif

  // FSM: state register.
  always_ff @(posedge clk or posedge rst) begin : p_state
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // FSM: next state. en=0 wins over everything, then load.
  always_comb begin : p_next
    state_d = state_q;
    if (!en) begin
      state_d = ST_IDLE;
    end else if (load) begin
      state_d = ST_RUN;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_RUN;
        ST_RUN:  if (do_step && step_wraps && (HOLD_STEPS > 0)) state_d = ST_HOLD;
        ST_HOLD: if (hold_done) state_d = ST_RUN;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // FSM: outputs.
  always_comb begin : p_out
    busy = (state_q != ST_IDLE);
  end

  // Datapath. line_out is updated together with offset_q from the same next
  // offset value, so the window appears the cycle after the tick.
  always_ff @(posedge clk or posedge rst) begin : p_data
    if (rst) begin
      msg_q    <= BLANK_MSG;
      offset_q <= '0;
      presc_q  <= '0;
      hold_q   <= '0;
      line_out <= BLANK_LINE;
      wrap     <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (load) begin
        msg_q    <= msg_in;
        offset_q <= '0;
        presc_q  <= '0;
        hold_q   <= '0;
        line_out <= window(msg_in, '0);
      end else begin
        if ((state_q == ST_IDLE) || tick) presc_q <= '0;
        else                              presc_q <= presc_q + PW'(1);

        // Hold count lives only inside HOLD; it is zero on every HOLD entry.
        if ((state_q != ST_HOLD) || !en) hold_q <= '0;
        else if (tick)                   hold_q <= (hold_q == HOLD_LAST) ? '0 : hold_q + HW'(1);

        if (do_step) begin
          offset_q <= offset_step;
          line_out <= window(msg_q, offset_step);
          wrap     <= step_wraps;
        end
      end
    end
  end

endmodule
